// File: rtl/xvga_pkg.sv
// Shared XVGA 1024x768@60 timing constants and pixel-path types.
package xvga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1344
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 806
    localparam int HS_START = H_ACTIVE + H_FP;                   // 1048
    localparam int HS_END   = HS_START + H_SYNC - 1;             // 1183
    localparam int VS_START = V_ACTIVE + V_FP;                   // 771
    localparam int VS_END   = VS_START + V_SYNC - 1;             // 776

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef logic [HCNT_W-1:0] hcount_t;
    typedef logic [VCNT_W-1:0] vcount_t;
    typedef logic [23:0]       rgb24_t;   // {r[23:16], g[15:8], b[7:0]}

endpackage

// File: rtl/xvga_sync_gen_if.sv
// Pixel-coordinate interface between the sync generator and the renderers / VGA pins.
interface xvga_sync_gen_if;

    xvga_pkg::hcount_t hcount;
    xvga_pkg::vcount_t vcount;
    logic              hsync;
    logic              vsync;
    logic              blank;
    logic              frame_start;
    xvga_pkg::rgb24_t  pixel_in;
    logic              hsync_out;
    logic              vsync_out;
    logic              blank_out;
    xvga_pkg::rgb24_t  pixel_out;

    // Timing source: drives coordinates and pin-side video, takes the composited pixel.
    modport master (
        output hcount, vcount, hsync, vsync, blank, frame_start,
        output hsync_out, vsync_out, blank_out, pixel_out,
        input  pixel_in
    );

    // Renderer / pin side.
    modport slave (
        input  hcount, vcount, hsync, vsync, blank, frame_start,
        input  hsync_out, vsync_out, blank_out, pixel_out,
        output pixel_in
    );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth register delay with an async reset to a chosen idle word; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] IDLE  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_ni;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;

            // Shift the word one stage per clock; reset parks every stage at IDLE.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xvga_sync_gen.sv
// XVGA timing generator: coordinate counters, registered sync/blank flags and a
// latency-matched, blank-masked output register for the VGA pins.
module xvga_sync_gen
    import xvga_pkg::*;
#(
    parameter int H_ACTIVE = xvga_pkg::H_ACTIVE,
    parameter int H_FP     = xvga_pkg::H_FP,
    parameter int H_SYNC   = xvga_pkg::H_SYNC,
    parameter int H_BP     = xvga_pkg::H_BP,
    parameter int V_ACTIVE = xvga_pkg::V_ACTIVE,
    parameter int V_FP     = xvga_pkg::V_FP,
    parameter int V_SYNC   = xvga_pkg::V_SYNC,
    parameter int V_BP     = xvga_pkg::V_BP,
    parameter int PIX_LAT  = 1
) (
    input logic             vclock,
    input logic             reset_n,
    xvga_sync_gen_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Compare constants sized to the counter widths.
    localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
    localparam hcount_t H_BLANK  = hcount_t'(H_ACTIVE);
    localparam hcount_t HS_FIRST = hcount_t'(H_ACTIVE + H_FP);
    localparam hcount_t HS_LAST  = hcount_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam vcount_t V_LAST   = vcount_t'(V_TOTAL - 1);
    localparam vcount_t V_BLANK  = vcount_t'(V_ACTIVE);
    localparam vcount_t VS_FIRST = vcount_t'(V_ACTIVE + V_FP);
    localparam vcount_t VS_LAST  = vcount_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (PIX_LAT < 0 || PIX_LAT > 3 ||
            H_TOTAL > (1 << HCNT_W) || V_TOTAL > (1 << VCNT_W)) begin : g_bad_params
            $error("xvga_sync_gen: PIX_LAT must be 0..3 and H/V totals must fit the counters");
        end
    endgenerate

    hcount_t hcount_q, hcount_d;
    vcount_t vcount_q, vcount_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    blank_q, blank_d;
    logic    fstart_q, fstart_d;

    // Next coordinates, and flags decoded from them so they move on the same edge.
    always_comb begin
        hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        hsync_d  = ~((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST));
        vsync_d  = ~((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST));
        blank_d  = (hcount_d >= H_BLANK) || (vcount_d >= V_BLANK);
        fstart_d = (hcount_d == '0) && (vcount_d == '0);
    end

    // Counter and flag registers; reset parks on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            blank_q  <= 1'b1;
            fstart_q <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            fstart_q <= fstart_d;
        end
    end

    // Flags wait out the renderer latency so they line up with pixel_in: {hsync, vsync, blank}.
    logic [2:0] flags_dly;

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIX_LAT),
        .IDLE  (3'b111)
    ) u_flag_dly (
        .clk_i  (vclock),
        .rst_ni (reset_n),
        .d_i    ({hsync_q, vsync_q, blank_q}),
        .q_o    (flags_dly)
    );

    logic   hsync_out_q, vsync_out_q, blank_out_q;
    rgb24_t pixel_out_q;

    // Pin-side output register; the pixel is forced black whenever the aligned blank is set.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_out_q <= 1'b1;
            vsync_out_q <= 1'b1;
            blank_out_q <= 1'b1;
            pixel_out_q <= '0;
        end else begin
            hsync_out_q <= flags_dly[2];
            vsync_out_q <= flags_dly[1];
            blank_out_q <= flags_dly[0];
            pixel_out_q <= flags_dly[0] ? '0 : vif.pixel_in;
        end
    end

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.blank       = blank_q;
    assign vif.frame_start = fstart_q;
    assign vif.hsync_out   = hsync_out_q;
    assign vif.vsync_out   = vsync_out_q;
    assign vif.blank_out   = blank_out_q;
    assign vif.pixel_out   = pixel_out_q;

endmodule

// File: tb/tb_xvga_sync_gen.sv
// Directed bench for xvga_sync_gen: full-size timing at PIX_LAT=1, a shrunken-timing
// instance for frame-level checks, and full-size instances at PIX_LAT 0/2/3.
module tb_xvga_sync_gen;
    import xvga_pkg::*;

    logic vclock  = 1'b0;
    logic reset_n = 1'b0;
    always #5 vclock = ~vclock;

    int checks = 0;
    int errors = 0;

    xvga_sync_gen_if vif_a();
    xvga_sync_gen_if vif_s();
    xvga_sync_gen_if vif_0();
    xvga_sync_gen_if vif_2();
    xvga_sync_gen_if vif_3();

    xvga_sync_gen #(.PIX_LAT(1)) u_dut (.vclock(vclock), .reset_n(reset_n), .vif(vif_a));

    // Small frame: H 16+2+3+3=24, V 8+1+2+2=13, vsync low on lines 9..10.
    xvga_sync_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2), .PIX_LAT(1)
    ) u_small (.vclock(vclock), .reset_n(reset_n), .vif(vif_s));

    xvga_sync_gen #(.PIX_LAT(0)) u_lat0 (.vclock(vclock), .reset_n(reset_n), .vif(vif_0));
    xvga_sync_gen #(.PIX_LAT(2)) u_lat2 (.vclock(vclock), .reset_n(reset_n), .vif(vif_2));
    xvga_sync_gen #(.PIX_LAT(3)) u_lat3 (.vclock(vclock), .reset_n(reset_n), .vif(vif_3));

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge vclock);
        checks++;
        if ({vif_a.hcount, vif_a.vcount} !== {11'd1343, 10'd805}) begin
            errors++;
            $display("FAIL reset_counts got h=%0d v=%0d want h=1343 v=805", vif_a.hcount, vif_a.vcount);
        end
        checks++;
        if ({vif_a.hsync, vif_a.vsync, vif_a.blank, vif_a.frame_start,
             vif_a.hsync_out, vif_a.vsync_out, vif_a.blank_out} !== 7'b1110111) begin
            errors++;
            $display("FAIL reset_flags got %b want 1110111", {vif_a.hsync, vif_a.vsync, vif_a.blank,
                     vif_a.frame_start, vif_a.hsync_out, vif_a.vsync_out, vif_a.blank_out});
        end
        checks++;
        if (vif_a.pixel_out !== 24'h0) begin
            errors++;
            $display("FAIL reset_pixel_out got %h want 000000", vif_a.pixel_out);
        end
        checks++;
        if ({vif_s.hcount, vif_s.vcount} !== {11'd23, 10'd12}) begin
            errors++;
            $display("FAIL reset_small_counts got h=%0d v=%0d want h=23 v=12", vif_s.hcount, vif_s.vcount);
        end
        reset_n = 1'b1;
        @(posedge vclock); #1;
        checks++;
        if ({vif_a.hcount, vif_a.vcount} !== {11'd0, 10'd0}) begin
            errors++;
            $display("FAIL first_edge_counts got h=%0d v=%0d want h=0 v=0", vif_a.hcount, vif_a.vcount);
        end
        checks++;
        if ({vif_a.frame_start, vif_a.blank, vif_a.hsync, vif_a.vsync} !== 4'b1011) begin
            errors++;
            $display("FAIL first_edge_flags got fs/bl/hs/vs=%b want 1011",
                     {vif_a.frame_start, vif_a.blank, vif_a.hsync, vif_a.vsync});
        end
        checks++;
        if ({vif_s.hcount, vif_s.vcount, vif_s.frame_start} !== {11'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL first_edge_small got h=%0d v=%0d fs=%b want 0 0 1",
                     vif_s.hcount, vif_s.vcount, vif_s.frame_start);
        end
    endtask

    // One full line from (0,0): hsync, blank, frame_start decoded per pixel.
    task automatic test_line_timing();
        int hs_low = 0;
        for (int i = 0; i < 1344; i++) begin
            logic exp_hs, exp_bl, exp_fs;
            @(negedge vclock);
            exp_hs = !(i >= 1048 && i <= 1183);
            exp_bl = (i >= 1024);
            exp_fs = (i == 0);
            if (vif_a.hsync === 1'b0) hs_low++;
            checks++;
            if ({vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.vsync, vif_a.blank, vif_a.frame_start}
                !== {11'(i), 10'd0, exp_hs, 1'b1, exp_bl, exp_fs}) begin
                errors++;
                $display("FAIL line_pixel got h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b want h=%0d v=0 hs=%b vs=1 bl=%b fs=%b",
                         vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.vsync, vif_a.blank,
                         vif_a.frame_start, i, exp_hs, exp_bl, exp_fs);
            end
        end
        checks++;
        if (hs_low !== 136) begin
            errors++;
            $display("FAIL hsync_width got %0d want 136", hs_low);
        end
        @(negedge vclock);
        checks++;
        if ({vif_a.hcount, vif_a.vcount, vif_a.frame_start} !== {11'd0, 10'd1, 1'b0}) begin
            errors++;
            $display("FAIL line_wrap got h=%0d v=%0d fs=%b want h=0 v=1 fs=0",
                     vif_a.hcount, vif_a.vcount, vif_a.frame_start);
        end
    endtask

    // Renderer model with one clock of latency; red must land exactly 2 clocks after hcount=100.
    task automatic test_latency();
        hcount_t hcur, hp1, hp2;
        rgb24_t  exp_px;
        int      red_cnt = 0;
        hp1  = '1;
        hp2  = '1;
        hcur = vif_a.hcount;
        for (int n = 0; n < 1400; n++) begin
            @(posedge vclock); #1;
            vif_a.pixel_in = (hcur == 11'd100) ? 24'hFF0000 : 24'h0;
            @(negedge vclock);
            hp2    = hp1;
            hp1    = hcur;
            hcur   = vif_a.hcount;
            exp_px = (hp2 == 11'd100) ? 24'hFF0000 : 24'h0;
            if (vif_a.pixel_out === 24'hFF0000) red_cnt++;
            checks++;
            if (vif_a.pixel_out !== exp_px) begin
                errors++;
                $display("FAIL latency_pixel got %h want %h (h=%0d)", vif_a.pixel_out, exp_px, hcur);
            end
            if (vif_a.blank_out === 1'b1) begin
                checks++;
                if (vif_a.pixel_out !== 24'h0) begin
                    errors++;
                    $display("FAIL blank_mask got %h want 000000", vif_a.pixel_out);
                end
            end
        end
        vif_a.pixel_in = 24'h0;
        checks++;
        if (red_cnt !== 1) begin
            errors++;
            $display("FAIL latency_count got %0d want 1", red_cnt);
        end
    endtask

    // Frame-level checks on the small instance: vsync window, fall spacing, one frame_start per frame.
    task automatic test_frame_timing();
        logic prev_vs;
        int   nfalls = 0, fall1 = 0, fall2 = 0, low_len = 0, fs_cnt = 0;
        prev_vs = vif_s.vsync;
        for (int n = 0; n < 1000; n++) begin
            logic exp_vs, exp_fs;
            @(negedge vclock);
            exp_vs = !(vif_s.vcount >= 10'd9 && vif_s.vcount <= 10'd10);
            exp_fs = (vif_s.hcount == 11'd0) && (vif_s.vcount == 10'd0);
            checks++;
            if ({vif_s.vsync, vif_s.frame_start} !== {exp_vs, exp_fs}) begin
                errors++;
                $display("FAIL frame_flags got vs=%b fs=%b want vs=%b fs=%b (h=%0d v=%0d)",
                         vif_s.vsync, vif_s.frame_start, exp_vs, exp_fs, vif_s.hcount, vif_s.vcount);
            end
            if (prev_vs === 1'b1 && vif_s.vsync === 1'b0) begin
                nfalls++;
                if (nfalls == 1) begin
                    fall1 = n;
                    checks++;
                    if ({vif_s.hcount, vif_s.vcount} !== {11'd0, 10'd9}) begin
                        errors++;
                        $display("FAIL vsync_fall_pos got h=%0d v=%0d want h=0 v=9", vif_s.hcount, vif_s.vcount);
                    end
                end else if (nfalls == 2) begin
                    fall2 = n;
                end
            end
            if (nfalls == 1 && vif_s.vsync === 1'b0) low_len++;
            if (nfalls == 1 && vif_s.frame_start === 1'b1) fs_cnt++;
            prev_vs = vif_s.vsync;
        end
        checks++;
        if (nfalls < 2) begin
            errors++;
            $display("FAIL vsync_falls got %0d falls want >=2 within 1000 clocks", nfalls);
        end else begin
            checks++;
            if (fall2 - fall1 !== 312) begin
                errors++;
                $display("FAIL vsync_period got %0d want 312", fall2 - fall1);
            end
        end
        checks++;
        if (low_len !== 48) begin
            errors++;
            $display("FAIL vsync_width got %0d want 48", low_len);
        end
        checks++;
        if (fs_cnt !== 1) begin
            errors++;
            $display("FAIL frame_start_count got %0d want 1", fs_cnt);
        end
    endtask

    // Reset dropped inside the hsync pulse must release both syncs immediately.
    task automatic test_mid_reset();
        int n = 0;
        while (vif_a.hcount !== 11'd1100 && n < 3000) begin
            @(negedge vclock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL mid_reset_wait got timeout want hcount=1100");
        end
        checks++;
        if ({vif_a.hsync, vif_a.hsync_out} !== 2'b00) begin
            errors++;
            $display("FAIL pre_reset_hsync got hs=%b hso=%b want 00", vif_a.hsync, vif_a.hsync_out);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({vif_a.hsync, vif_a.hsync_out, vif_a.vsync_out, vif_a.blank_out} !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset_flags got hs/hso/vso/blo=%b want 1111",
                     {vif_a.hsync, vif_a.hsync_out, vif_a.vsync_out, vif_a.blank_out});
        end
        checks++;
        if ({vif_a.pixel_out, vif_a.hcount} !== {24'h0, 11'd1343}) begin
            errors++;
            $display("FAIL async_reset_state got px=%h h=%0d want px=000000 h=1343",
                     vif_a.pixel_out, vif_a.hcount);
        end
        @(negedge vclock);
        reset_n = 1'b1;
        @(posedge vclock); #1;
        checks++;
        if ({vif_a.hcount, vif_a.vcount, vif_a.frame_start} !== {11'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart got h=%0d v=%0d fs=%b want 0 0 1",
                     vif_a.hcount, vif_a.vcount, vif_a.frame_start);
        end
    endtask

    // hsync_out/blank_out must trail hsync/blank by exactly PIX_LAT+1 clocks.
    task automatic test_pix_lat_sweep();
        int       lat[3] = '{0, 2, 3};
        logic [4:0] hs_hist[3];
        logic [4:0] bl_hist[3];
        logic     hs[3], hso[3], bl[3], blo[3];
        rgb24_t   po[3];
        int       hso_low[3] = '{0, 0, 0};
        for (int d = 0; d < 3; d++) begin
            hs_hist[d] = '1;
            bl_hist[d] = '1;
        end
        for (int n = 0; n < 1400; n++) begin
            @(negedge vclock);
            hs[0] = vif_0.hsync; hso[0] = vif_0.hsync_out; bl[0] = vif_0.blank; blo[0] = vif_0.blank_out; po[0] = vif_0.pixel_out;
            hs[1] = vif_2.hsync; hso[1] = vif_2.hsync_out; bl[1] = vif_2.blank; blo[1] = vif_2.blank_out; po[1] = vif_2.pixel_out;
            hs[2] = vif_3.hsync; hso[2] = vif_3.hsync_out; bl[2] = vif_3.blank; blo[2] = vif_3.blank_out; po[2] = vif_3.pixel_out;
            for (int d = 0; d < 3; d++) begin
                hs_hist[d] = {hs_hist[d][3:0], hs[d]};
                bl_hist[d] = {bl_hist[d][3:0], bl[d]};
                if (hso[d] === 1'b0) hso_low[d]++;
                checks++;
                if ({hso[d], blo[d]} !== {hs_hist[d][lat[d]+1], bl_hist[d][lat[d]+1]}) begin
                    errors++;
                    $display("FAIL lag_pixlat%0d got hso=%b blo=%b want hso=%b blo=%b (n=%0d)",
                             lat[d], hso[d], blo[d], hs_hist[d][lat[d]+1], bl_hist[d][lat[d]+1], n);
                end
                checks++;
                if (po[d] !== (blo[d] ? 24'h0 : 24'h123456)) begin
                    errors++;
                    $display("FAIL pixel_pixlat%0d got %h want %h (blank_out=%b)",
                             lat[d], po[d], blo[d] ? 24'h0 : 24'h123456, blo[d]);
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (hso_low[d] !== 136) begin
                errors++;
                $display("FAIL hsync_out_width_pixlat%0d got %0d want 136", lat[d], hso_low[d]);
            end
        end
    endtask

    initial begin
        vif_a.pixel_in = 24'h0;
        vif_s.pixel_in = 24'h0;
        vif_0.pixel_in = 24'h123456;
        vif_2.pixel_in = 24'h123456;
        vif_3.pixel_in = 24'h123456;
        test_reset();
        test_line_timing();
        test_latency();
        test_frame_timing();
        test_mid_reset();
        test_pix_lat_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
